// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out receiver: collects WIDTH bits MSB first and hands the
// finished word to a consumer through a Valid/Ack handshake with overrun detection.
module sipo_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             RxEn,
    input  logic             SerialIn,
    input  logic             Clear,
    input  logic             Ack,
    output logic [WIDTH-1:0] ParalelOut,
    output logic             Valid,
    output logic             Busy,
    output logic             Overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-2:0]   r_shift;
    logic [WIDTH-1:0]   r_out;
    logic               r_valid;
    logic               r_busy;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_word;
    logic               w_last;

    // Only the low WIDTH-1 bits are kept; the incoming bit completes the word.
    assign w_word = {r_shift, SerialIn};
    assign w_last = (r_state == SHIFT) && (r_count == CW'(WIDTH - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (Clear) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (Ack) begin
                r_valid <= 1'b0;
            end
            if (RxEn) begin
                r_shift <= w_word[WIDTH-2:0];
                if (w_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                    // An Ack on the completion edge frees the holding register in time.
                    if (!r_valid || Ack) begin
                        r_out   <= w_word;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign ParalelOut = r_out;
    assign Valid      = r_valid;
    assign Busy       = r_busy;
    assign Overrun    = r_overrun;

endmodule
